// File: rtl/gpio_ckpt_pkg.sv
// Shared types and pad-map constants for the checkpoint code emitter.
// The map covers the low/high GPIO banks, the FIFO entry layout and the FSM states.
package gpio_ckpt_pkg;

  localparam int CKPT_CODE_W = 6;
  localparam int LO_BANK_LSB = 0;
  localparam int HI_BANK_LSB = 32;
  localparam int IO_W        = 38;

  typedef enum logic {
    CKPT_BANK_LO = 1'b0,
    CKPT_BANK_HI = 1'b1
  } ckpt_bank_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_HOLD     = 2'd1,
    ST_WAIT_ACK = 2'd2
  } ckpt_state_e;

  typedef struct packed {
    ckpt_bank_e             bank;
    logic [CKPT_CODE_W-1:0] code;
  } ckpt_entry_t;

  // A HOLD_CYCLES of 0 still holds a code for one cycle.
  function automatic int hold_eff(input int hold_cycles);
    return (hold_cycles < 1) ? 1 : hold_cycles;
  endfunction

endpackage

// File: rtl/gpio_checkpoint_tx_fifo.sv
// Synchronous FIFO for checkpoint entries with full/empty/level flags.
// Pointers wrap modulo DEPTH (a power of two); reset flushes by clearing pointers and count.
module ckpt_fifo #(
  parameter int DATA_W = 7,
  parameter int DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [DATA_W-1:0]      wdata,
  output logic [DATA_W-1:0]      rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              do_push;
  logic              do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  // Storage carries no reset: stale words are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign level = count;

endmodule

// File: rtl/gpio_checkpoint_tx.sv
// Checkpoint code emitter: queues {bank, code} entries and holds each on io[5:0] or io[37:32].
// Optional GPIO_CKPT_ACK_EN adds a synchronized monitor acknowledge handshake after each hold.
//
//  state       | meaning
//  ST_IDLE     | waiting for a queued entry; pops and loads a bank when one is present
//  ST_HOLD     | code on pins, counting down the minimum hold time
//  ST_WAIT_ACK | (GPIO_CKPT_ACK_EN only) hold done, waiting for the monitor acknowledge
module gpio_checkpoint_tx
  import gpio_ckpt_pkg::*;
#(
  parameter int CODE_W      = 6,
  parameter int FIFO_DEPTH  = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int CNT_W       = 16
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_i,
  input  logic                        wr_valid_i,
  output logic                        wr_ready_o,
  input  logic [CODE_W-1:0]           wr_code_i,
  input  logic                        wr_bank_i,
  output logic [IO_W-1:0]             io_out_o,
  output logic [IO_W-1:0]             io_oeb_o,
  output logic                        busy_o,
  output logic [$clog2(FIFO_DEPTH):0] level_o
`ifdef GPIO_CKPT_ACK_EN
  ,
  input  logic                        ack_i
`endif
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(hold_eff(HOLD_CYCLES) - 1);

  ckpt_state_e       state;
  logic [CNT_W-1:0]  cnt;
  logic [CODE_W-1:0] lo_code;
  logic [CODE_W-1:0] hi_code;
  logic              lo_en;
  logic              hi_en;

  ckpt_entry_t       wr_entry;
  ckpt_entry_t       head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_push;
  logic              fifo_pop;
  logic              ack_armed;

  assign wr_entry.bank = ckpt_bank_e'(wr_bank_i);
  assign wr_entry.code = wr_code_i;
  assign wr_ready_o    = !fifo_full;
  assign fifo_push     = wr_valid_i && !fifo_full;
  assign fifo_pop      = (state == ST_IDLE) && !fifo_empty && ack_armed;

  ckpt_fifo #(
    .DATA_W ($bits(ckpt_entry_t)),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (wr_entry),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level_o)
  );

`ifdef GPIO_CKPT_ACK_EN
  logic ack_meta;
  logic ack_sync;
  logic ack_seen_low;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ack_meta <= 1'b0;
      ack_sync <= 1'b0;
    end else begin
      ack_meta <= ack_i;
      ack_sync <= ack_meta;
    end
  end

  // One acknowledge releases one code: the ack must drop before the next pop.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ack_seen_low <= 1'b1;
    end else if (state == ST_WAIT_ACK && ack_sync) begin
      ack_seen_low <= 1'b0;
    end else if (!ack_sync) begin
      ack_seen_low <= 1'b1;
    end
  end

  assign ack_armed = ack_seen_low;
`else
  assign ack_armed = 1'b1;
`endif

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      lo_code <= '0;
      hi_code <= '0;
      lo_en   <= 1'b0;
      hi_en   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (fifo_pop) begin
            state <= ST_HOLD;
            cnt   <= CNT_LOAD;
            if (head.bank == CKPT_BANK_HI) begin
              hi_code <= head.code;
              hi_en   <= 1'b1;
            end else begin
              lo_code <= head.code;
              lo_en   <= 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (cnt == '0) begin
`ifdef GPIO_CKPT_ACK_EN
            state <= ST_WAIT_ACK;
`else
            state <= ST_IDLE;
`endif
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
`ifdef GPIO_CKPT_ACK_EN
        ST_WAIT_ACK: begin
          if (ack_sync) state <= ST_IDLE;
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Unused pads io[31:6] stay driven low with output disabled.
  always_comb begin
    io_out_o = '0;
    io_oeb_o = '1;
    io_out_o[LO_BANK_LSB +: CODE_W] = lo_code;
    io_oeb_o[LO_BANK_LSB +: CODE_W] = {CODE_W{~lo_en}};
    io_out_o[HI_BANK_LSB +: CODE_W] = hi_code;
    io_oeb_o[HI_BANK_LSB +: CODE_W] = {CODE_W{~hi_en}};
  end

  assign busy_o = (state != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_gpio_checkpoint_tx.sv
// Bench for gpio_checkpoint_tx: random and directed pushes scored against a timing model
// in which each code loads at max(accept+1, previous load + HOLD + 1).
module tb_gpio_checkpoint_tx;

  localparam int H     = 16;
  localparam int DEPTH = 4;

  logic        wb_clk_i   = 1'b0;
  logic        wb_rst_i   = 1'b0;
  logic        wr_valid_i = 1'b0;
  logic        wr_bank_i  = 1'b0;
  logic [5:0]  wr_code_i  = '0;
  logic        wr_ready_o;
  logic        busy_o;
  logic [37:0] io_out_o;
  logic [37:0] io_oeb_o;
  logic [2:0]  level_o;
`ifdef GPIO_CKPT_ACK_EN
  logic        ack_i = 1'b0;
`endif

  gpio_checkpoint_tx #(
    .CODE_W      (6),
    .FIFO_DEPTH  (DEPTH),
    .HOLD_CYCLES (H),
    .CNT_W       (16)
  ) dut (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_i   (wb_rst_i),
    .wr_valid_i (wr_valid_i),
    .wr_ready_o (wr_ready_o),
    .wr_code_i  (wr_code_i),
    .wr_bank_i  (wr_bank_i),
    .io_out_o   (io_out_o),
    .io_oeb_o   (io_oeb_o),
    .busy_o     (busy_o),
    .level_o    (level_o)
`ifdef GPIO_CKPT_ACK_EN
    ,
    .ack_i      (ack_i)
`endif
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  // Reference model: a queue of accepted codes with their predicted load cycle.
  typedef struct {
    int       accept;
    int       load;
    bit       bank;
    bit [5:0] code;
  } exp_t;

  exp_t        sb[$];
  int          last_load = -1000;
  int          cur_load  = -1000;
  bit          sb_on     = 1'b0;
  logic [37:0] m_out     = '0;
  logic [37:0] m_oeb     = '1;
  int          m_lvl;
  bit          m_hold;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic int model_level();
    int n = 0;
    foreach (sb[i]) if (sb[i].accept <= cyc && sb[i].load > cyc) n++;
    return n;
  endfunction

  always @(negedge wb_clk_i) begin
    if (sb_on) begin
      while (sb.size() > 0 && sb[0].load == cyc) begin
        m_out[(sb[0].bank ? 32 : 0) +: 6] = sb[0].code;
        m_oeb[(sb[0].bank ? 32 : 0) +: 6] = 6'h00;
        cur_load = sb[0].load;
        void'(sb.pop_front());
      end
      m_lvl  = model_level();
      m_hold = (cyc >= cur_load) && (cyc < cur_load + H);
      check("io_out",   64'(io_out_o),   64'(m_out));
      check("io_oeb",   64'(io_oeb_o),   64'(m_oeb));
      check("level",    64'(level_o),    64'(m_lvl));
      check("wr_ready", 64'(wr_ready_o), 64'(m_lvl < DEPTH));
      check("busy",     64'(busy_o),     64'((m_lvl > 0) || m_hold));
    end
  end

  task automatic drive(input bit v, input bit b, input bit [5:0] c, output bit acc);
    int ld;
    @(negedge wb_clk_i);
    wr_valid_i = v;
    wr_bank_i  = b;
    wr_code_i  = c;
    acc = v && (model_level() < DEPTH);
    if (acc) begin
      ld = (cyc + 2 > last_load + H + 1) ? cyc + 2 : last_load + H + 1;
      sb.push_back('{accept: cyc + 1, load: ld, bank: b, code: c});
      last_load = ld;
    end
  endtask

  task automatic push_blocking(input bit b, input bit [5:0] c);
    bit acc = 1'b0;
    int n = 0;
    while (!acc && n < 200) begin
      drive(1'b1, b, c, acc);
      n++;
    end
    n_tests++;
    if (!acc) begin
      n_fail++;
      $display("FAIL push_timeout code=%0h got=no_accept want=accept", c);
    end
  endtask

  task automatic idle();
    bit acc;
    drive(1'b0, 1'b0, 6'h00, acc);
  endtask

  task automatic drain();
    int n = 0;
    idle();
    while ((sb.size() > 0 || cyc <= last_load + H + 1) && n < 1000) begin
      @(negedge wb_clk_i);
      n++;
    end
    n_tests++;
    if (n >= 1000) begin
      n_fail++;
      $display("FAIL drain_timeout got=%0d want=<1000", n);
    end
  endtask

  // Asserts reset between clock edges and checks the pins go hi-Z without a clock.
  task automatic do_reset();
    sb_on = 1'b0;
    wr_valid_i = 1'b0;
    @(posedge wb_clk_i);
    #2 wb_rst_i = 1'b1;
    #1;
    check("rst_oeb",   64'(io_oeb_o),   64'h3F_FFFF_FFFF);
    check("rst_out",   64'(io_out_o),   64'h0);
    check("rst_ready", 64'(wr_ready_o), 64'h1);
    check("rst_level", 64'(level_o),    64'h0);
    check("rst_busy",  64'(busy_o),     64'h0);
    sb.delete();
    m_out     = '0;
    m_oeb     = '1;
    cur_load  = -1000;
    last_load = -1000;
    repeat (2) @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    sb_on = 1'b1;
  endtask

  initial begin
    do_reset();
`ifdef GPIO_CKPT_ACK_EN
    begin
      int n;
      sb_on = 1'b0;
      push_blocking(1'b0, 6'h37);
      push_blocking(1'b0, 6'h38);
      push_blocking(1'b0, 6'h39);
      wr_valid_i = 1'b0;
      repeat (120) @(negedge wb_clk_i);
      check("ack_hold", 64'(io_out_o[5:0]), 64'h37);
      ack_i = 1'b1;
      repeat (3) @(negedge wb_clk_i);
      ack_i = 1'b0;
      n = 0;
      while (io_out_o[5:0] != 6'h38 && n < 12) begin
        @(negedge wb_clk_i);
        n++;
      end
      check("ack_advance", 64'(io_out_o[5:0]), 64'h38);
      repeat (60) @(negedge wb_clk_i);
      check("ack_single", 64'(io_out_o[5:0]), 64'h38);
    end
`else
    begin
      bit acc;
      push_blocking(1'b1, 6'h20);
      drain();
      push_blocking(1'b1, 6'h31);
      push_blocking(1'b1, 6'h32);
      push_blocking(1'b1, 6'h33);
      drain();
      for (int i = 0; i < 6; i++) push_blocking(1'b0, 6'(6'h10 + i));
      drain();
      push_blocking(1'b1, 6'h34);
      push_blocking(1'b0, 6'h35);
      push_blocking(1'b0, 6'h35);
      drain();
      for (int i = 0; i < 300; i++) begin
        drive($urandom_range(0, 3) == 0, 1'($urandom), 6'($urandom), acc);
      end
      drain();
      push_blocking(1'b1, 6'h2A);
      push_blocking(1'b0, 6'h15);
      push_blocking(1'b1, 6'h0F);
      idle();
      repeat (5) @(negedge wb_clk_i);
      do_reset();
      repeat (30) @(negedge wb_clk_i);
      push_blocking(1'b0, 6'h3C);
      drain();
    end
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
